// File: rtl/dmem_responder.sv
// Data-memory responder: word LW/SW target for execute, reads return after READ_LATENCY cycles.
// Latency: READ_LATENCY cycles request->readdata_valid; write errors flag 1 cycle after the request.
// Backpressure: none; one request accepted every cycle, responses in request order.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dmem_control,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_writedata,
  output logic [31:0] dmem_readdata,
  output logic        dmem_readdata_valid,
  output logic        dmem_error,
  output logic [15:0] err_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("dmem_responder: READ_LATENCY must be in 1..4");
    end
    if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 || (1 << AW) != DEPTH_WORDS) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be a power of 2 in 16..65536");
    end
  endgenerate

  logic [31:0]   offset;
  logic          in_range;
  logic          req_err;
  logic          req_rd;
  logic          req_wr;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;

  // BASE_ADDR is aligned to the window, so the offset's upper bits being zero is the upper bound test
  // and its low two bits are the request's byte offset.
  assign offset   = dmem_addr - BASE_ADDR;
  assign in_range = (dmem_addr >= BASE_ADDR) && (offset[31:AW+2] == '0);
  assign req_err  = (offset[1:0] != 2'b00) || !in_range;
  assign idx      = offset[AW+1:2];
  assign req_rd   = (dmem_control == 2'b01);
  assign req_wr   = (dmem_control == 2'b10);

  logic [31:0] ram [DEPTH_WORDS];

  assign rd_word = ram[idx];

  always_ff @(posedge clk) begin
    if (req_wr && !req_err) begin
      ram[idx] <= dmem_writedata;
    end
  end

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_err;
  logic [31:0]             pipe_dat [READ_LATENCY];
  logic                    wr_err_q;
  logic [16:0]             cnt_sum;

  // Data stages load only behind a valid slot, so the last stage holds the most recent read value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= req_rd;
      pipe_err[0] <= req_rd && req_err;
      if (req_rd) begin
        pipe_dat[0] <= req_err ? ERR_DATA : rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        if (pipe_vld[i-1]) begin
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
      wr_err_q <= req_wr && req_err;
    end
  end

  assign dmem_readdata       = pipe_dat[READ_LATENCY-1];
  assign dmem_readdata_valid = pipe_vld[READ_LATENCY-1];
  assign dmem_error          = pipe_err[READ_LATENCY-1] | wr_err_q;

  // A read error and a write error can land in the same cycle; both requests are counted.
  assign cnt_sum = {1'b0, err_count} + {16'd0, pipe_err[READ_LATENCY-1]} + {16'd0, wr_err_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else begin
      err_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule
